// File: rtl/parc_core_hazard_ctrl.sv
// Hazard and stall control for the 5-stage PARC core: bypass selects, load/muldiv
// interlocks, the muldiv request/response handshake FSM and the register-file write port.
module parc_core_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       inst_val_Dhl,
  input  logic       rs_en_Dhl,
  input  logic       rt_en_Dhl,
  input  logic [4:0] rs_addr_Dhl,
  input  logic [4:0] rt_addr_Dhl,
  input  logic       rf_wen_Dhl,
  input  logic [4:0] rf_waddr_Dhl,
  input  logic       is_load_Dhl,
  input  logic       is_muldiv_Dhl,
  input  logic       squash_Dhl,
  input  logic       dmemresp_val_Mhl,
  output logic       muldivreq_val,
  input  logic       muldivreq_rdy,
  input  logic       muldivresp_val,
  output logic       muldivresp_rdy,
  output logic       stall_Fhl,
  output logic       stall_Dhl,
  output logic       stall_Xhl,
  output logic       stall_Mhl,
  output logic       stall_Whl,
  output logic       rs_X_byp_Dhl,
  output logic       rt_X_byp_Dhl,
  output logic       rs_M_byp_Dhl,
  output logic       rt_M_byp_Dhl,
  output logic       rs_W_byp_Dhl,
  output logic       rt_W_byp_Dhl,
  output logic       rf_wen_Whl,
  output logic [4:0] rf_waddr_Whl
);

  // Later stages only carry the fields something downstream still consumes.
  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] waddr;
    logic       is_load;
    logic       is_muldiv;
  } x_stage_t;

  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] waddr;
    logic       is_load;
  } m_stage_t;

  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] waddr;
  } w_stage_t;

  typedef enum logic {MD_IDLE = 1'b0, MD_WAIT = 1'b1} md_state_e;

  x_stage_t  x_q, x_d;
  m_stage_t  m_q, m_d;
  w_stage_t  w_q, w_d;
  md_state_e md_state_q, md_state_d;

  logic       md_req_val, md_resp_rdy;
  logic       md_wait_resp, md_resp_fire;
  logic       dmem_wait, muldiv_busy;
  logic       stall_m, stall_x, stall_d;
  logic       squash_eff, x_result_ok;
  logic       load_use, muldiv_use;
  logic [1:0] src_en;
  logic [4:0] src_addr [2];
  logic [1:0] match_x, match_m, match_w;
  logic [1:0] byp_x, byp_m, byp_w;

  assign src_en      = {rt_en_Dhl, rs_en_Dhl};
  assign src_addr[0] = rs_addr_Dhl;
  assign src_addr[1] = rt_addr_Dhl;

  // Index 0 is rs, index 1 is rt; X beats M beats W.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic src_live;
      assign src_live    = src_en[gi] & inst_val_Dhl & (src_addr[gi] != 5'd0);
      assign match_x[gi] = src_live & x_q.val & x_q.wen & (x_q.waddr == src_addr[gi]);
      assign match_m[gi] = src_live & m_q.val & m_q.wen & (m_q.waddr == src_addr[gi]);
      assign match_w[gi] = src_live & w_q.val & w_q.wen & (w_q.waddr == src_addr[gi]);
      assign byp_x[gi]   = match_x[gi] & x_result_ok;
      assign byp_m[gi]   = match_m[gi] & ~match_x[gi];
      assign byp_w[gi]   = match_w[gi] & ~match_x[gi] & ~match_m[gi];
    end
  endgenerate

  // Muldiv FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) md_state_q <= MD_IDLE;
    else        md_state_q <= md_state_d;
  end

  // Muldiv FSM: next state
  always_comb begin
    md_state_d = md_state_q;
    case (md_state_q)
      MD_IDLE: if (md_req_val & muldivreq_rdy)    md_state_d = MD_WAIT;
      MD_WAIT: if (muldivresp_val & md_resp_rdy)  md_state_d = MD_IDLE;
      default:                                     md_state_d = MD_IDLE;
    endcase
  end

  // Muldiv FSM: outputs
  always_comb begin
    md_req_val  = 1'b0;
    md_resp_rdy = 1'b0;
    case (md_state_q)
      MD_IDLE: md_req_val  = x_q.val & x_q.is_muldiv;
      MD_WAIT: md_resp_rdy = ~stall_m;
      default: ;
    endcase
  end

  assign md_wait_resp = (md_state_q == MD_WAIT) & muldivresp_val;
  assign md_resp_fire = md_wait_resp & md_resp_rdy;

  assign dmem_wait   = m_q.val & m_q.is_load & ~dmemresp_val_Mhl;
  assign muldiv_busy = x_q.val & x_q.is_muldiv & ~md_resp_fire;
  assign x_result_ok = ~x_q.is_load & (~x_q.is_muldiv | md_wait_resp);
  assign load_use    = (|match_x) & x_q.is_load;
  assign muldiv_use  = (|match_x) & x_q.is_muldiv & ~md_wait_resp;

  // A taken branch only counts once X can move; it then overrides any D interlock.
  assign stall_m    = dmem_wait;
  assign stall_x    = stall_m | muldiv_busy;
  assign squash_eff = squash_Dhl & ~stall_x;
  assign stall_d    = stall_x | ((load_use | muldiv_use) & ~squash_eff);

  always_comb begin
    x_d = x_q;
    m_d = m_q;
    if (!stall_x) begin
      x_d.val       = inst_val_Dhl & ~stall_d & ~squash_eff;
      x_d.wen       = rf_wen_Dhl;
      x_d.waddr     = rf_waddr_Dhl;
      x_d.is_load   = is_load_Dhl;
      x_d.is_muldiv = is_muldiv_Dhl;
    end
    if (!stall_m) begin
      m_d.val     = x_q.val & ~stall_x;
      m_d.wen     = x_q.wen;
      m_d.waddr   = x_q.waddr;
      m_d.is_load = x_q.is_load;
    end
    w_d.val   = m_q.val & ~stall_m;
    w_d.wen   = m_q.wen;
    w_d.waddr = m_q.waddr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Control outputs are forced low for as long as reset is held.
  assign muldivreq_val  = reset & md_req_val;
  assign muldivresp_rdy = reset & md_resp_rdy;
  assign stall_Whl      = 1'b0;
  assign stall_Mhl      = reset & stall_m;
  assign stall_Xhl      = reset & stall_x;
  assign stall_Dhl      = reset & stall_d;
  assign stall_Fhl      = reset & stall_d;
  assign rs_X_byp_Dhl   = reset & byp_x[0];
  assign rt_X_byp_Dhl   = reset & byp_x[1];
  assign rs_M_byp_Dhl   = reset & byp_m[0];
  assign rt_M_byp_Dhl   = reset & byp_m[1];
  assign rs_W_byp_Dhl   = reset & byp_w[0];
  assign rt_W_byp_Dhl   = reset & byp_w[1];
  assign rf_wen_Whl     = reset & w_q.val & w_q.wen & (w_q.waddr != 5'd0);
  assign rf_waddr_Whl   = w_q.waddr;

endmodule

// File: tb/tb_parc_core_hazard_ctrl.sv
// Scoreboard bench for parc_core_hazard_ctrl: each driven cycle pushes its expected
// control outputs; a negedge monitor pops and compares them.
module tb_parc_core_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       inst_val_Dhl, rs_en_Dhl, rt_en_Dhl;
  logic [4:0] rs_addr_Dhl, rt_addr_Dhl;
  logic       rf_wen_Dhl;
  logic [4:0] rf_waddr_Dhl;
  logic       is_load_Dhl, is_muldiv_Dhl, squash_Dhl, dmemresp_val_Mhl;
  logic       muldivreq_val, muldivreq_rdy, muldivresp_val, muldivresp_rdy;
  logic       stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl;
  logic       rs_X_byp_Dhl, rt_X_byp_Dhl, rs_M_byp_Dhl, rt_M_byp_Dhl;
  logic       rs_W_byp_Dhl, rt_W_byp_Dhl;
  logic       rf_wen_Whl;
  logic [4:0] rf_waddr_Whl;

  always #5 clk = ~clk;

  parc_core_hazard_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .inst_val_Dhl     (inst_val_Dhl),
    .rs_en_Dhl        (rs_en_Dhl),
    .rt_en_Dhl        (rt_en_Dhl),
    .rs_addr_Dhl      (rs_addr_Dhl),
    .rt_addr_Dhl      (rt_addr_Dhl),
    .rf_wen_Dhl       (rf_wen_Dhl),
    .rf_waddr_Dhl     (rf_waddr_Dhl),
    .is_load_Dhl      (is_load_Dhl),
    .is_muldiv_Dhl    (is_muldiv_Dhl),
    .squash_Dhl       (squash_Dhl),
    .dmemresp_val_Mhl (dmemresp_val_Mhl),
    .muldivreq_val    (muldivreq_val),
    .muldivreq_rdy    (muldivreq_rdy),
    .muldivresp_val   (muldivresp_val),
    .muldivresp_rdy   (muldivresp_rdy),
    .stall_Fhl        (stall_Fhl),
    .stall_Dhl        (stall_Dhl),
    .stall_Xhl        (stall_Xhl),
    .stall_Mhl        (stall_Mhl),
    .stall_Whl        (stall_Whl),
    .rs_X_byp_Dhl     (rs_X_byp_Dhl),
    .rt_X_byp_Dhl     (rt_X_byp_Dhl),
    .rs_M_byp_Dhl     (rs_M_byp_Dhl),
    .rt_M_byp_Dhl     (rt_M_byp_Dhl),
    .rs_W_byp_Dhl     (rs_W_byp_Dhl),
    .rt_W_byp_Dhl     (rt_W_byp_Dhl),
    .rf_wen_Whl       (rf_wen_Whl),
    .rf_waddr_Whl     (rf_waddr_Whl)
  );

  // stalls = {F,D,X,M,W}; byp = {rsX,rtX,rsM,rtM,rsW,rtW}; md = {req_val,resp_rdy};
  // rf = {wen,waddr} with waddr only meaningful when wen is set.
  typedef struct {
    string      tag;
    logic [4:0] stalls;
    logic [5:0] byp;
    logic [1:0] md;
    logic [5:0] rf;
  } exp_t;

  localparam logic [4:0] ST_0 = 5'b00000;
  localparam logic [4:0] ST_D = 5'b11000;
  localparam logic [4:0] ST_X = 5'b11100;
  localparam logic [4:0] ST_M = 5'b11110;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] o_st;
    logic [5:0] o_byp;
    logic [1:0] o_md;
    logic [5:0] o_rf;
    if (sb_q.size() > 0) begin
      e     = sb_q.pop_front();
      o_st  = {stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl};
      o_byp = {rs_X_byp_Dhl, rt_X_byp_Dhl, rs_M_byp_Dhl, rt_M_byp_Dhl, rs_W_byp_Dhl, rt_W_byp_Dhl};
      o_md  = {muldivreq_val, muldivresp_rdy};
      o_rf  = rf_wen_Whl ? {1'b1, rf_waddr_Whl} : 6'd0;
      $display("%0t %s st=%b byp=%b md=%b rf=%b", $time, e.tag, o_st, o_byp, o_md, o_rf);
      check_eq({e.tag, ".stall"}, 32'(o_st),  32'(e.stalls));
      check_eq({e.tag, ".byp"},   32'(o_byp), 32'(e.byp));
      check_eq({e.tag, ".md"},    32'(o_md),  32'(e.md));
      check_eq({e.tag, ".rf"},    32'(o_rf),  32'(e.rf));
    end
  end

  task automatic d_inst(input logic v, input logic rse, input logic [4:0] rs,
                        input logic rte, input logic [4:0] rt, input logic wen,
                        input logic [4:0] wa, input logic ld, input logic md);
    inst_val_Dhl  = v;
    rs_en_Dhl     = rse;
    rs_addr_Dhl   = rs;
    rt_en_Dhl     = rte;
    rt_addr_Dhl   = rt;
    rf_wen_Dhl    = wen;
    rf_waddr_Dhl  = wa;
    is_load_Dhl   = ld;
    is_muldiv_Dhl = md;
  endtask

  task automatic d_idle();
    d_inst(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step(input string tag, input logic [4:0] st, input logic [5:0] by,
                      input logic [1:0] md, input logic [5:0] rf);
    exp_t e;
    e.tag    = tag;
    e.stalls = st;
    e.byp    = by;
    e.md     = md;
    e.rf     = rf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    squash_Dhl       = 1'b0;
    dmemresp_val_Mhl = 1'b1;
    muldivreq_rdy    = 1'b1;
    muldivresp_val   = 1'b0;
    d_inst(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    step("reset", ST_0, 6'd0, 2'b00, 6'd0);
    reset = 1'b1;

    // Plain ALU producer seen from X, M and W
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
    step("add_r3", ST_0, 6'd0, 2'b00, 6'd0);
    d_inst(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("byp_x", ST_0, 6'b100000, 2'b00, 6'd0);
    step("byp_m", ST_0, 6'b001000, 2'b00, 6'd0);
    d_inst(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    step("byp_w", ST_0, 6'b000011, 2'b00, 6'b100011);
    d_idle();
    step("idle", ST_0, 6'd0, 2'b00, 6'd0);

    // Load-use: one stall, then M bypass
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    step("lw_r5", ST_0, 6'd0, 2'b00, 6'd0);
    d_inst(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step("ld_use", ST_D, 6'd0, 2'b00, 6'd0);
    step("ld_byp_m", ST_0, 6'b000100, 2'b00, 6'd0);
    d_idle();
    step("ld_wb", ST_0, 6'd0, 2'b00, 6'b100101);

    // Load waiting on data memory for three cycles
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    step("lw_r6", ST_0, 6'd0, 2'b00, 6'd0);
    d_idle();
    step("lw_r6_x", ST_0, 6'd0, 2'b00, 6'd0);
    dmemresp_val_Mhl = 1'b0;
    for (int i = 0; i < 3; i++) step("dmem_wait", ST_M, 6'd0, 2'b00, 6'd0);
    dmemresp_val_Mhl = 1'b1;
    step("dmem_resp", ST_0, 6'd0, 2'b00, 6'd0);
    step("dmem_wb", ST_0, 6'd0, 2'b00, 6'b100110);

    // Multiply with a 33-cycle latency and a dependent instruction in D
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1);
    step("mul_r7", ST_0, 6'd0, 2'b00, 6'd0);
    d_inst(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("md_issue", ST_X, 6'd0, 2'b10, 6'd0);
    for (int k = 1; k < 33; k++) step("md_wait", ST_X, 6'd0, 2'b01, 6'd0);
    muldivresp_val = 1'b1;
    step("md_resp", ST_0, 6'b100000, 2'b01, 6'd0);
    muldivresp_val = 1'b0;
    d_idle();
    step("md_m", ST_0, 6'd0, 2'b00, 6'd0);
    step("md_wb", ST_0, 6'd0, 2'b00, 6'b100111);

    // r0 is never a dependency and never written
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    step("lw_r0", ST_0, 6'd0, 2'b00, 6'd0);
    d_inst(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("r0_x", ST_0, 6'd0, 2'b00, 6'd0);
    step("r0_m", ST_0, 6'd0, 2'b00, 6'd0);
    step("r0_w", ST_0, 6'd0, 2'b00, 6'd0);

    // Squash beats a load-use hazard and leaves a bubble in X
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    step("lw_r5b", ST_0, 6'd0, 2'b00, 6'd0);
    d_inst(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    squash_Dhl = 1'b1;
    step("squash", ST_0, 6'd0, 2'b00, 6'd0);
    squash_Dhl = 1'b0;
    d_inst(1'b1, 1'b1, 5'd8, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step("sq_bubble", ST_0, 6'b000100, 2'b00, 6'd0);
    d_idle();
    step("sq_wb", ST_0, 6'd0, 2'b00, 6'b100101);

    // Reset while the multiplier is busy abandons the operation
    d_inst(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1);
    step("mul_rst", ST_0, 6'd0, 2'b00, 6'd0);
    d_idle();
    step("md_issue2", ST_X, 6'd0, 2'b10, 6'd0);
    step("md_wait2", ST_X, 6'd0, 2'b01, 6'd0);
    reset          = 1'b0;
    muldivresp_val = 1'b1;
    d_inst(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    step("in_rst", ST_0, 6'd0, 2'b00, 6'd0);
    reset = 1'b1;
    d_idle();
    step("late_resp", ST_0, 6'd0, 2'b00, 6'd0);
    muldivresp_val = 1'b0;
    step("post_rst", ST_0, 6'd0, 2'b00, 6'd0);

    @(negedge clk);
    check_eq("drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
